// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i widths, data-memory constants and arbiter state type
package rv32i_pkg;
  localparam int DPW      = 32;
  localparam int DMEM_AW  = 10;
  localparam int DMEM_LAT = 2;

  typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-winner memory
// Grants only while en_i is high; last_gnt moves to whichever port was granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_o      = 2'b00;
    last_gnt_d = last_gnt_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o != 2'b00) last_gnt_d = gnt_o[1];
  end

  // Resetting to port 1 hands port 0 the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= 1'b1;
    else        last_gnt_q <= last_gnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one single-port data RAM between the pipeline and the loader
// Round-robin grants in IDLE; reads hold the RAM for MEM_LAT cycles and answer one cycle later.
module dmem_arbiter
  import rv32i_pkg::*;
#(
  parameter int DPW     = rv32i_pkg::DPW,
  parameter int AW      = DMEM_AW,
  parameter int MEM_LAT = DMEM_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           p0_req_i,
  input  logic           p0_we_i,
  input  logic [AW-1:0]  p0_addr_i,
  input  logic [DPW-1:0] p0_wdata_i,
  output logic           p0_gnt_o,
  output logic           p0_rvalid_o,
  output logic [DPW-1:0] p0_rdata_o,
  output logic           stall_o,
  input  logic           p1_req_i,
  input  logic           p1_we_i,
  input  logic [AW-1:0]  p1_addr_i,
  input  logic [DPW-1:0] p1_wdata_i,
  output logic           p1_gnt_o,
  output logic           p1_rvalid_o,
  output logic [DPW-1:0] p1_rdata_o,
  output logic           mem_en_o,
  output logic           mem_we_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic [DPW-1:0] mem_wdata_o,
  input  logic [DPW-1:0] mem_rdata_i
);
  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           owner_q, owner_d;
  logic [1:0]     rvalid_q, rvalid_d;
  logic [DPW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]     gnt;
  logic           win;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({p1_req_i, p0_req_i}),
    .en_i  (state_q == ARB_IDLE),
    .gnt_o (gnt)
  );

  assign win         = gnt[1];
  assign p0_gnt_o    = gnt[0];
  assign p1_gnt_o    = gnt[1];
  assign mem_en_o    = |gnt;
  assign mem_we_o    = mem_en_o & (win ? p1_we_i : p0_we_i);
  assign mem_addr_o  = win ? p1_addr_i : p0_addr_i;
  assign mem_wdata_o = win ? p1_wdata_i : p0_wdata_i;

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = rdata0_q;
  assign p1_rdata_o  = rdata1_q;
  assign stall_o     = (p0_req_i & ~gnt[0]) | ((state_q == ARB_RD_WAIT) & ~owner_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_en_o && !mem_we_o) begin
          state_d = ARB_RD_WAIT;
          cnt_d   = CW'(MEM_LAT);
          owner_d = win;
        end
      end
      ARB_RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // cnt==1 is the cycle the RAM presents the word for the read.
        if (cnt_q == CW'(1)) begin
          state_d           = ARB_IDLE;
          rvalid_d[owner_q] = 1'b1;
          if (owner_q) rdata1_d = mem_rdata_i;
          else         rdata0_d = mem_rdata_i;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench with a transaction-level reference model of the arbiter
module tb_dmem_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 10;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_wdata_i, p1_wdata_i;
  logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o, stall_o;
  logic [DW-1:0] p0_rdata_o, p1_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.DPW(DW), .AW(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o), .stall_o(stall_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM with LAT-cycle read pipeline
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] rd_s1, rd_s2;
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    rd_s1 <= (mem_en_o && !mem_we_o) ? ram[mem_addr_o] : 32'hBAD0_BAD0;
    rd_s2 <= rd_s1;
  end
  assign mem_rdata_i = rd_s2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the RAM is busy until a read's answer cycle; answers are scheduled events.
  logic [DW-1:0] m_ram [0:1023];
  int            m_cyc, m_busy_until, m_last, m_rd_owner, m_resp_cyc, m_resp_port, m_w;
  bit            m_pend, m_we;
  logic [DW-1:0] m_resp_data, m_rd0, m_rd1, m_wdata;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_rv, m_g;
  bit            m_stall;

  initial begin
    m_cyc = 0; m_busy_until = 0; m_last = 1; m_rd_owner = 0; m_pend = 0;
    m_resp_cyc = 0; m_resp_port = 0; m_rd0 = '0; m_rd1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy_until = 0; m_last = 1; m_pend = 0; m_rd0 = '0; m_rd1 = '0;
        chk("mdl_rst_rvalid", {30'd0, p1_rvalid_o, p0_rvalid_o}, 32'd0);
        chk("mdl_rst_rdata0", p0_rdata_o, 32'd0);
        chk("mdl_rst_rdata1", p1_rdata_o, 32'd0);
        chk("mdl_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("mdl_rst_mem_en", {31'd0, mem_en_o}, 32'd0);
      end else begin
        m_rv = 2'b00;
        if (m_pend && m_resp_cyc == m_cyc) begin
          m_rv[m_resp_port] = 1'b1;
          if (m_resp_port == 1) m_rd1 = m_resp_data;
          else                  m_rd0 = m_resp_data;
          m_pend = 0;
        end
        m_g = 2'b00;
        if (m_cyc >= m_busy_until) begin
          if (p0_req_i && p1_req_i) m_g = (m_last == 1) ? 2'b01 : 2'b10;
          else                      m_g = {p1_req_i, p0_req_i};
        end
        m_stall = (p0_req_i && !m_g[0]) || (m_cyc < m_busy_until && m_rd_owner == 0);
        chk("mdl_gnt", {30'd0, p1_gnt_o, p0_gnt_o}, {30'd0, m_g});
        chk("mdl_rvalid", {30'd0, p1_rvalid_o, p0_rvalid_o}, {30'd0, m_rv});
        chk("mdl_rdata0", p0_rdata_o, m_rd0);
        chk("mdl_rdata1", p1_rdata_o, m_rd1);
        chk("mdl_stall", {31'd0, stall_o}, {31'd0, m_stall});
        chk("mdl_mem_en", {31'd0, mem_en_o}, {31'd0, (m_g != 2'b00)});
        if (m_g != 2'b00) begin
          m_w     = m_g[1] ? 1 : 0;
          m_last  = m_w;
          m_we    = m_g[1] ? p1_we_i : p0_we_i;
          m_addr  = m_g[1] ? p1_addr_i : p0_addr_i;
          m_wdata = m_g[1] ? p1_wdata_i : p0_wdata_i;
          chk("mdl_mem_we", {31'd0, mem_we_o}, {31'd0, m_we});
          chk("mdl_mem_addr", {22'd0, mem_addr_o}, {22'd0, m_addr});
          if (m_we) begin
            chk("mdl_mem_wdata", mem_wdata_o, m_wdata);
            m_ram[m_addr] = m_wdata;
          end else begin
            m_busy_until = m_cyc + LAT + 1;
            m_rd_owner   = m_w;
            m_pend       = 1;
            m_resp_cyc   = m_cyc + LAT + 1;
            m_resp_port  = m_w;
            m_resp_data  = m_ram[m_addr];
          end
        end
      end
      m_cyc++;
    end
  end

  bit g0, g1, got;
  int k0, k1;
  logic [1:0] exp_w [4];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = '0;
      m_ram[i] = '0;
    end
    rst_n = 1'b0;
    p0_req_i = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0;
    p1_req_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_p0_rdata", p0_rdata_o, 32'd0);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    step();

    // 1: port-0 store granted combinationally
    p0_req_i = 1; p0_we_i = 1; p0_addr_i = 10'h004; p0_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_p0_gnt", {31'd0, p0_gnt_o}, 32'd1);
    chk("t1_mem_we", {31'd0, mem_we_o}, 32'd1);
    chk("t1_mem_addr", {22'd0, mem_addr_o}, 32'h004);
    chk("t1_stall", {31'd0, stall_o}, 32'd0);
    step();
    p0_req_i = 0;

    // 2: port-0 load, stall while in flight, answer at t+3
    p0_req_i = 1; p0_we_i = 0; p0_addr_i = 10'h004;
    @(negedge clk);
    chk("t2_p0_gnt", {31'd0, p0_gnt_o}, 32'd1);
    chk("t2_stall_t0", {31'd0, stall_o}, 32'd0);
    step();
    p0_req_i = 0;
    @(negedge clk);
    chk("t2_stall_t1", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    chk("t2_stall_t2", {31'd0, stall_o}, 32'd1);
    chk("t2_rvalid_t2", {31'd0, p0_rvalid_o}, 32'd0);
    @(negedge clk);
    chk("t2_rvalid_t3", {31'd0, p0_rvalid_o}, 32'd1);
    chk("t2_rdata_t3", p0_rdata_o, 32'hDEADBEEF);
    chk("t2_stall_t3", {31'd0, stall_o}, 32'd0);
    step();

    // 3: after reset, both ports store every cycle -> p0,p1,p0,p1
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    k0 = 0; k1 = 0;
    exp_w = '{2'd0, 2'd1, 2'd0, 2'd1};
    p0_req_i = 1; p0_we_i = 1; p1_req_i = 1; p1_we_i = 1;
    p0_addr_i = 10'h010; p0_wdata_i = 32'hA0;
    p1_addr_i = 10'h020; p1_wdata_i = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_p0_gnt", {31'd0, p0_gnt_o}, {31'd0, (exp_w[i] == 2'd0)});
      chk("t3_p1_gnt", {31'd0, p1_gnt_o}, {31'd0, (exp_w[i] == 2'd1)});
      chk("t3_stall", {31'd0, stall_o}, {31'd0, (exp_w[i] == 2'd1)});
      g0 = p0_gnt_o; g1 = p1_gnt_o;
      step();
      if (g0) begin k0++; p0_addr_i = AW'(10'h010 + k0); p0_wdata_i = 32'hA0 + k0; end
      if (g1) begin k1++; p1_addr_i = AW'(10'h020 + k1); p1_wdata_i = 32'hB0 + k1; end
    end
    p0_req_i = 0; p1_req_i = 0;

    // 4: p1 load in flight blocks a p0 store until p1_rvalid
    p1_req_i = 1; p1_we_i = 0; p1_addr_i = 10'h020;
    @(negedge clk);
    chk("t4_p1_gnt", {31'd0, p1_gnt_o}, 32'd1);
    step();
    p1_req_i = 0;
    p0_req_i = 1; p0_we_i = 1; p0_addr_i = 10'h030; p0_wdata_i = 32'h55;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("t4_p0_gnt_wait", {31'd0, p0_gnt_o}, 32'd0);
      chk("t4_stall_wait", {31'd0, stall_o}, 32'd1);
    end
    @(negedge clk);
    chk("t4_p1_rvalid", {31'd0, p1_rvalid_o}, 32'd1);
    chk("t4_p1_rdata", p1_rdata_o, 32'hB0);
    chk("t4_p0_gnt", {31'd0, p0_gnt_o}, 32'd1);
    chk("t4_stall", {31'd0, stall_o}, 32'd0);
    step();
    p0_req_i = 0;

    // 5: complete one p0 load, then reset mid-way through the next
    p0_req_i = 1; p0_we_i = 0; p0_addr_i = 10'h011;
    @(negedge clk);
    step();
    p0_req_i = 0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t5_pre_rdata", p0_rdata_o, 32'hA1);
    step();
    p0_req_i = 1; p0_addr_i = 10'h010;
    @(negedge clk);
    chk("t5_p0_gnt", {31'd0, p0_gnt_o}, 32'd1);
    step();
    p0_req_i = 0;
    rst_n = 1'b0;
    #1;
    chk("t5_rdata_clr", p0_rdata_o, 32'd0);
    chk("t5_stall_clr", {31'd0, stall_o}, 32'd0);
    chk("t5_rvalid_clr", {31'd0, p0_rvalid_o}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_rvalid", {31'd0, p0_rvalid_o}, 32'd0);
    end
    step();

    // 6: loader writes 1..4 to 0..3 back to back, then reads them back
    p1_req_i = 1; p1_we_i = 1;
    for (int i = 0; i < 4; i++) begin
      p1_addr_i = AW'(i); p1_wdata_i = 32'(i + 1);
      @(negedge clk);
      chk("t6_wr_gnt", {31'd0, p1_gnt_o}, 32'd1);
      chk("t6_wr_we", {31'd0, mem_we_o}, 32'd1);
      step();
    end
    p1_req_i = 0;
    for (int i = 0; i < 4; i++) begin
      p1_req_i = 1; p1_we_i = 0; p1_addr_i = AW'(i);
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (p1_gnt_o) got = 1;
      end
      chk("t6_rd_gnt", {31'd0, got}, 32'd1);
      step();
      p1_req_i = 0;
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (p1_rvalid_o) begin
          got = 1;
          chk("t6_rd_data", p1_rdata_o, 32'(i + 1));
        end
      end
      chk("t6_rd_rvalid", {31'd0, got}, 32'd1);
      step();
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
